// File: rtl/regfile_incdec_sequencer_if.sv
// regfile_incdec_sequencer_if: request, slice-bus and status signals of the sequencer
interface regfile_incdec_sequencer_if #(parameter int WIDTH = 16, parameter int NREGS = 14);
  logic start;
  logic [3:0] reg_idx;
  logic [1:0] op;
  logic [WIDTH-1:0] bus_in;
  logic [NREGS-1:0] regsel;
  logic pc_wr;
  logic [WIDTH-1:0] pc_din;
  logic [WIDTH-1:0] result;
  logic [2:0] flags;
  logic busy;
  logic done;
  modport master (output start, reg_idx, op, bus_in,
                  input regsel, pc_wr, pc_din, result, flags, busy, done);
  modport slave (input start, reg_idx, op, bus_in,
                 output regsel, pc_wr, pc_din, result, flags, busy, done);
endinterface

// File: rtl/regfile_incdec_sequencer.sv
// regfile_incdec_sequencer: selects a register slice, reads it, inc/dec/copies it and writes it back
module regfile_incdec_sequencer #(parameter int WIDTH = 16, parameter int NREGS = 14) (
  input logic eclk,
  input logic erst,
  regfile_incdec_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, SELECT = 3'd1, CAPTURE = 3'd2, COMPUTE = 3'd3, WRITEBACK = 3'd4, DONE = 3'd5;
  logic [2:0] state;
  logic [3:0] idx;
  logic [1:0] opr;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] result;
  logic [2:0] flags;
  logic [WIDTH-1:0] next_val;
  logic carry;
  // arithmetic on the captured operand; carry flags wrap in either direction
  always_comb begin
    next_val = opr == 2'b01 ? operand + WIDTH'(1) : opr == 2'b10 ? operand - WIDTH'(1) : operand;
    carry = (opr == 2'b01 && &operand) || (opr == 2'b10 && ~|operand);
  end
  // sequencer: request latch, slice settle, capture, compute, optional writeback, done pulse
  always_ff @(posedge eclk or posedge erst)
    if (erst) begin
      state <= IDLE;
      idx <= '0;
      opr <= '0;
      operand <= '0;
      result <= '0;
      flags <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          idx <= bus.reg_idx;
          opr <= bus.op;
          state <= int'(bus.reg_idx) >= NREGS ? DONE : SELECT;
          if (int'(bus.reg_idx) >= NREGS) flags <= 3'b100;
        end
        SELECT: state <= CAPTURE;
        CAPTURE: begin
          operand <= ~bus.bus_in;
          state <= COMPUTE;
        end
        COMPUTE: begin
          result <= next_val;
          flags <= {1'b0, carry, next_val == '0};
          state <= opr == 2'b11 ? DONE : WRITEBACK;
        end
        WRITEBACK: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  assign bus.regsel = (state >= SELECT && state <= WRITEBACK) ? NREGS'(1) << idx : '0;
  assign bus.pc_wr = state == WRITEBACK;
  assign bus.pc_din = result;
  assign bus.result = result;
  assign bus.flags = flags;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
endmodule

// File: tb/tb_regfile_incdec_sequencer.sv
// tb_regfile_incdec_sequencer: directed requests checked against a cycle-level behavioural model
module tb_regfile_incdec_sequencer;
  localparam int WIDTH = 16;
  localparam int NREGS = 14;
  logic eclk = 0;
  logic erst = 1;
  logic chk_en = 0;
  int checks = 0;
  int errors = 0;
  regfile_incdec_sequencer_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();
  regfile_incdec_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (.eclk(eclk), .erst(erst), .bus(bus));
  always #5 eclk = ~eclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: k counts cycles since acceptance (0 = idle), n is the request's total latency
  int k = 0;
  int n = 1;
  logic bad = 0;
  logic [3:0] m_idx = 0;
  logic [1:0] m_op = 0;
  logic [15:0] m_opnd = 0;
  logic [15:0] m_res = 0;
  logic [2:0] m_flags = 0;
  always @(posedge eclk or posedge erst) begin
    if (erst) begin
      k = 0;
      m_res = 0;
      m_flags = 0;
    end else if (k == 0) begin
      if (bus.start) begin
        m_idx = bus.reg_idx;
        m_op = bus.op;
        bad = int'(bus.reg_idx) >= NREGS;
        n = bad ? 1 : (bus.op == 2'b11 ? 4 : 5);
        if (bad) m_flags = 3'b100;
        k = 1;
      end
    end else begin
      if (k == 2) m_opnd = ~bus.bus_in;
      if (k == 3) begin
        case (m_op)
          2'b01: m_res = m_opnd + 16'd1;
          2'b10: m_res = m_opnd - 16'd1;
          default: m_res = m_opnd;
        endcase
        m_flags = {1'b0, (m_op == 2'b01 && m_opnd == 16'hFFFF) || (m_op == 2'b10 && m_opnd == 16'h0000), m_res == 16'h0000};
      end
      k = (k == n) ? 0 : k + 1;
    end
  end

  always @(negedge eclk) if (chk_en) begin
    chk("regsel", 32'(bus.regsel), (k >= 1 && k < n && !bad) ? 32'(14'(1) << m_idx) : 32'd0);
    chk("pc_wr", 32'(bus.pc_wr), 32'(k == 4 && n == 5));
    chk("pc_din", 32'(bus.pc_din), 32'(m_res));
    chk("result", 32'(bus.result), 32'(m_res));
    chk("flags", 32'(bus.flags), 32'(m_flags));
    chk("busy", 32'(bus.busy), 32'(k != 0));
    chk("done", 32'(bus.done), 32'(k != 0 && k == n));
  end

  int dcyc;
  logic wr_seen;
  logic [15:0] wr_val;
  logic [13:0] rs_or;
  logic [2:0] fl;
  logic [15:0] res;

  task automatic run_op(input logic [3:0] idx, input logic [1:0] o, input logic [15:0] v);
    @(negedge eclk);
    bus.reg_idx = idx;
    bus.op = o;
    bus.bus_in = ~v;
    bus.start = 1;
    @(negedge eclk);
    bus.start = 0;
    bus.reg_idx = ~idx;
    bus.op = ~o;
    dcyc = 0;
    wr_seen = 0;
    wr_val = 0;
    rs_or = 0;
    fl = 0;
    res = 0;
    for (int c = 1; c <= 10; c++) begin
      rs_or |= bus.regsel;
      if (bus.pc_wr) begin
        wr_seen = 1;
        wr_val = bus.pc_din;
      end
      if (bus.done) begin
        dcyc = c;
        fl = bus.flags;
        res = bus.result;
        break;
      end
      @(negedge eclk);
    end
    if (dcyc == 0) chk("done_timeout", 32'(dcyc), 32'd1);
  endtask

  initial begin
    int cnt;
    bus.start = 0;
    bus.reg_idx = 0;
    bus.op = 0;
    bus.bus_in = '1;
    repeat (2) @(posedge eclk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_regsel", 32'(bus.regsel), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    #1 erst = 0;
    chk_en = 1;
    run_op(4'd0, 2'b01, 16'h12FF);
    chk("inc_done_cyc", 32'(dcyc), 32'd5);
    chk("inc_regsel", 32'(rs_or), 32'h0001);
    chk("inc_wr", 32'(wr_seen), 32'd1);
    chk("inc_pc_din", 32'(wr_val), 32'h1300);
    chk("inc_flags", 32'(fl), 32'b000);
    run_op(4'd8, 2'b10, 16'h0000);
    chk("dec_regsel", 32'(rs_or), 32'h0100);
    chk("dec_pc_din", 32'(wr_val), 32'hFFFF);
    chk("dec_flags", 32'(fl), 32'b010);
    run_op(4'd2, 2'b01, 16'hFFFF);
    chk("wrap_result", 32'(res), 32'h0000);
    chk("wrap_flags", 32'(fl), 32'b011);
    chk("wrap_wr", 32'(wr_seen), 32'd1);
    chk("wrap_pc_din", 32'(wr_val), 32'h0000);
    run_op(4'd5, 2'b00, 16'h0000);
    chk("copy_flags", 32'(fl), 32'b001);
    chk("copy_done_cyc", 32'(dcyc), 32'd5);
    run_op(4'd13, 2'b11, 16'hA5A5);
    chk("rd_result", 32'(res), 32'hA5A5);
    chk("rd_done_cyc", 32'(dcyc), 32'd4);
    chk("rd_wr", 32'(wr_seen), 32'd0);
    chk("rd_regsel", 32'(rs_or), 32'h2000);
    run_op(4'd14, 2'b01, 16'h1234);
    chk("bad_done_cyc", 32'(dcyc), 32'd1);
    chk("bad_flags", 32'(fl), 32'b100);
    chk("bad_regsel", 32'(rs_or), 32'h0000);
    // start held through busy: one operation only
    @(negedge eclk);
    bus.reg_idx = 4'd3;
    bus.op = 2'b01;
    bus.bus_in = ~16'h0041;
    bus.start = 1;
    cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge eclk);
      if (c == 3) bus.start = 0;
      if (bus.done) cnt++;
    end
    chk("ignored_start_dones", 32'(cnt), 32'd1);
    chk("ignored_start_result", 32'(bus.result), 32'h0042);
    // start held continuously: back-to-back acceptance
    @(negedge eclk);
    bus.reg_idx = 4'd1;
    bus.op = 2'b11;
    bus.bus_in = ~16'h0F0F;
    bus.start = 1;
    @(negedge eclk);
    cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.done) cnt++;
      if (c == 10) bus.start = 0;
      @(negedge eclk);
    end
    chk("b2b_dones", 32'(cnt), 32'd2);
    run_op(4'd6, 2'b01, 16'h00FF);
    // reset during CAPTURE
    @(negedge eclk);
    bus.reg_idx = 4'd4;
    bus.op = 2'b01;
    bus.bus_in = ~16'h0007;
    bus.start = 1;
    @(negedge eclk);
    bus.start = 0;
    @(posedge eclk);
    #2 erst = 1;
    bus.start = 1;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_regsel", 32'(bus.regsel), 32'd0);
    chk("arst_pc_wr", 32'(bus.pc_wr), 32'd0);
    chk("arst_pc_din", 32'(bus.pc_din), 32'd0);
    chk("arst_result", 32'(bus.result), 32'd0);
    chk("arst_flags", 32'(bus.flags), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    repeat (2) @(posedge eclk);
    #2 bus.start = 0;
    erst = 0;
    @(negedge eclk);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);
    run_op(4'd4, 2'b01, 16'h0007);
    chk("post_rst_done_cyc", 32'(dcyc), 32'd5);
    chk("post_rst_pc_din", 32'(wr_val), 32'h0008);
    repeat (3) @(negedge eclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/regfile_incdec_sequencer.md
REGFILE_INCDEC_SEQUENCER -- requirements
Module: regfile_incdec_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: number of regfile slices and the data width.
REQ-002 The block SHALL have parameter NREGS, default 14: number of one-hot register selects.
REQ-003 The block SHALL have port eclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port erst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-006 The block SHALL have port reg_idx, input, 4 bits: register number 0..NREGS-1; bit 0 = pc, bit 13 = af0, following the slice select order.
REQ-007 The block SHALL have port op, input, 2 bits: 00 = copy, 01 = increment, 10 = decrement, 11 = read only (no writeback).
REQ-008 The block SHALL have port bus_in, input, WIDTH bits: the slices' pc_dout bus, active-low, so value = ~bus_in.
REQ-009 The block SHALL have port regsel, output, NREGS bits: one-hot register select to all slices.
REQ-010 The block SHALL have port pc_wr, output, 1 bit: left-bus write strobe to all slices.
REQ-011 The block SHALL have port pc_din, output, WIDTH bits: true-polarity writeback data.
REQ-012 The block SHALL have port result, output, WIDTH bits: last computed value, held until the next compute.
REQ-013 The block SHALL have port flags, output, 3 bits: {err, carry, zero}.
REQ-014 The block SHALL have ports busy and done, output, 1 bit each: busy = not IDLE; done = one-cycle completion pulse.

Function
REQ-015 The block SHALL be an FSM with states IDLE, SELECT, CAPTURE, COMPUTE, WRITEBACK and DONE.
REQ-016 IDLE: on start=1, latch reg_idx and op; go to SELECT, or to DONE with err=1 when reg_idx >= NREGS.
REQ-017 regsel SHALL equal 1<<idx in SELECT, CAPTURE, COMPUTE and WRITEBACK, and SHALL be all-zero in every other state.
REQ-018 SELECT SHALL last exactly one cycle, the settle cycle for the registered pc_dout of the slices.
REQ-019 CAPTURE SHALL latch ~bus_in into an internal operand register at the end of its single cycle.
REQ-020 COMPUTE SHALL set result from the operand per op:
- 01: operand+1 mod 2^WIDTH.
- 10: operand-1 mod 2^WIDTH.
- 00 and 11: operand unchanged.
REQ-021 COMPUTE SHALL set zero = (result==0); carry = 1 only on 0xFFFF+1 or 0x0000-1; err = 0.
REQ-022 From COMPUTE the FSM SHALL go to WRITEBACK for op 00, 01 or 10, and directly to DONE for op 11.
REQ-023 WRITEBACK SHALL assert pc_wr=1 with pc_din=result for exactly one cycle; pc_wr SHALL be 0 in all other states.
REQ-024 DONE SHALL assert done=1 for one cycle and then return to IDLE.
REQ-025 Latency, with start sampled at edge 0:
- writeback ops: done high in cycle 5.
- op 11: done high in cycle 4.
- bad index: done high in cycle 1.
REQ-026 start SHALL be ignored while busy=1, with no queuing.
REQ-027 start SHALL be accepted in the first IDLE cycle after DONE, allowing back-to-back requests.
REQ-028 pc_din SHALL hold result outside WRITEBACK; the slices ignore it while pc_wr=0.
REQ-029 Changes on reg_idx or op after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-030 erst=1 SHALL immediately, without waiting for a clock edge, force state=IDLE and set:
- regsel=0, pc_wr=0, pc_din=0, result=0.
- flags=000, busy=0, done=0.
REQ-031 erst asserted mid-operation SHALL abort with no write strobe issued, and the FSM SHALL resume from IDLE on the first edge after release.
REQ-032 start SHALL NOT be sampled while erst=1.

Verification
REQ-033 Increment: reg_idx=0, op=01, bus_in=~16'h12FF.
- regsel=14'h0001 in cycles 1-4.
- pc_wr=1 with pc_din=16'h1300 in cycle 4.
- done in cycle 5; flags=000.
REQ-034 Decrement underflow: reg_idx=8, op=10, bus_in=~16'h0000.
- regsel=14'h0100.
- pc_din=16'hFFFF; flags=010.
REQ-035 Increment wrap: op=01, bus_in=~16'hFFFF.
- result=0, flags=011, pc_wr pulse with pc_din=0.
REQ-036 Read only: op=11, reg_idx=13, bus_in=~16'hA5A5.
- result=16'hA5A5 and done in cycle 4.
- pc_wr never asserted.
REQ-037 Bad index plus ignored start: reg_idx=14.
- done in cycle 1 with flags=100; regsel never nonzero.
- Then a valid start is accepted, and a second start during busy is ignored.
REQ-038 Reset during CAPTURE: all outputs go to reset values asynchronously, no pc_wr pulse occurs, and a new start after release completes normally.
